// File: rtl/imem_fetch_unit_pkg.sv
// imem_fetch_unit_pkg: shared state encoding, NOP word and RV32 encoding constants.
// Used by the fetch unit and by program-image generators that build instruction words.
package imem_fetch_unit_pkg;
    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic [31:0] rv_itype(input logic [11:0] imm, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd,
                                             input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
endpackage

// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if: load-port and fetch-port bundle of the instruction memory.
// master = boot loader / core side (drives load_*, run_*, fetch_*, stall);
// slave  = imem_fetch_unit (drives load_ready, load_err, fetch_*, busy, state_o).
interface imem_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    import imem_fetch_unit_pkg::*;
    logic                  load_valid;
    logic                  load_ready;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_err;
    logic                  run_start;
    logic                  run_stop;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  stall;
    logic [DATA_WIDTH-1:0] fetch_instr;
    logic                  fetch_valid;
    logic                  fetch_fault;
    logic                  busy;
    state_e                state_o;

    modport master (
        output load_valid, load_addr, load_data, run_start, run_stop, fetch_req, fetch_addr, stall,
        input  load_ready, load_err, fetch_instr, fetch_valid, fetch_fault, busy, state_o
    );
    modport slave (
        input  load_valid, load_addr, load_data, run_start, run_stop, fetch_req, fetch_addr, stall,
        output load_ready, load_err, fetch_instr, fetch_valid, fetch_fault, busy, state_o
    );
endinterface

// File: rtl/imem_fetch_unit_sram.sv
// imem_sram: synchronous-write, synchronous-read RAM that maps onto block RAM.
// Ports: clk_i; we_i/waddr_i/wdata_i write; re_i/raddr_i read, rdata_o holds when re_i=0.
module imem_sram #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction memory with run-time load port and 1-cycle stallable fetch.
// Ports: clk, reset (async, active-high); bus (slave modport) carries the load handshake,
// run_start/run_stop, fetch request/address/stall, registered fetch result, busy and state.
module imem_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_ADDR  = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(imem_fetch_unit_pkg::NOP_INSTR)
) (
    input logic               clk,
    input logic               reset,
    imem_fetch_unit_if.slave  bus
);
    import imem_fetch_unit_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_e                state_q;
    logic [AW-1:0]         cnt_q;
    logic                  valid_q, fault_q, sel_q, load_err_q;
    logic [ADDR_WIDTH-1:0] lword, fword;
    logic                  load_bad, fetch_bad, we, re;
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] wdata, rdata;

    // Range check runs on the full-width word index so out-of-range addresses never alias.
    assign lword     = BYTE_ADDR != 0 ? bus.load_addr >> 2 : bus.load_addr;
    assign fword     = BYTE_ADDR != 0 ? bus.fetch_addr >> 2 : bus.fetch_addr;
    assign load_bad  = (lword >> AW) != '0 || (BYTE_ADDR != 0 && bus.load_addr[1:0] != 2'b00);
    assign fetch_bad = (fword >> AW) != '0 || (BYTE_ADDR != 0 && bus.fetch_addr[1:0] != 2'b00);

    // CLEAR owns the write port; afterwards only accepted, in-range loads write.
    assign we    = state_q == ST_CLEAR || (state_q == ST_LOAD && bus.load_valid && !load_bad);
    assign waddr = state_q == ST_CLEAR ? cnt_q : lword[AW-1:0];
    assign wdata = state_q == ST_CLEAR ? NOP_INSTR : bus.load_data;
    // RAM output register doubles as the fetch register; not reading keeps it on stall.
    assign re    = state_q == ST_RUN && !bus.run_stop && !bus.stall && bus.fetch_req && !fetch_bad;

    imem_sram #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_sram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (fword[AW-1:0]),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            sel_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    load_err_q <= bus.load_valid && load_bad;
                    if (bus.run_start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.run_stop) begin
                        state_q <= ST_LOAD;
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                        sel_q   <= 1'b0;
                    end else if (!bus.stall) begin
                        valid_q <= bus.fetch_req;
                        fault_q <= bus.fetch_req && fetch_bad;
                        if (bus.fetch_req) sel_q <= !fetch_bad;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    // sel_q=0 (reset, LOAD, fault) presents the NOP instead of the RAM register.
    assign bus.fetch_instr = sel_q ? rdata : NOP_INSTR;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.load_err    = load_err_q;
    assign bus.load_ready  = state_q == ST_LOAD;
    assign bus.busy        = state_q == ST_CLEAR;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed tables, hand sequences and a random model check of imem_fetch_unit.
module tb_imem_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    imem_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    imem_fetch_unit #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .BYTE_ADDR(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return a[1:0] == 2'b00 && a < 32'h400;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 32'h400 + ($urandom_range(0, 63) << 2);
            1: return ($urandom_range(0, 63) << 2) + $urandom_range(1, 3);
            2: return $urandom;
            3: return 32'h3FC;
            default: return $urandom_range(0, 15) << 2;
        endcase
    endfunction

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 400) begin
            check({name, "_ready_low"}, {31'b0, bus.load_ready}, 32'd0);
            tick();
            n++;
        end
        check({name, "_clear_cycles"}, n, 256);
        check({name, "_state_load"}, {30'b0, bus.state_o}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = a;
        tick();
        bus.fetch_req = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic err);
        check("load_ready", {31'b0, bus.load_ready}, 32'd1);
        bus.load_valid = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_valid = 1'b0;
        check("load_err", {31'b0, bus.load_err}, {31'b0, err});
    endtask

    task automatic pulse_start();
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.run_stop = 1'b1;
        tick();
        bus.run_stop = 1'b0;
    endtask

    vec_t vecs[8];
    logic [31:0] mem [256];

    initial begin
        int mst;
        logic [31:0] exp_instr;
        logic exp_valid, exp_fault, exp_err;
        logic lv, fr, st, rs, rp;
        logic [31:0] la, ld, fa;

        bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.run_start = 1'b0; bus.run_stop = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.stall = 1'b0;

        vecs[0] = '{32'h0,   32'h2D90_0093, 1'b0};
        vecs[1] = '{32'h4,   32'h3E80_0113, 1'b0};
        vecs[2] = '{32'h8,   32'h0010_0193, 1'b0};
        vecs[3] = '{32'h6,   NOP,           1'b1};
        vecs[4] = '{32'h400, NOP,           1'b1};
        vecs[5] = '{32'hC,   NOP,           1'b0};
        vecs[6] = '{32'h3FC, NOP,           1'b0};
        vecs[7] = '{32'h4,   32'h3E80_0113, 1'b0};

        // reset state and clear duration
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd1);
        check("rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
        check("rst_instr", bus.fetch_instr, NOP);
        check("rst_state", {30'b0, bus.state_o}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        wait_clear("t1");

        pulse_start();
        check("t1_state_run", {30'b0, bus.state_o}, 32'd2);
        check("t1_ready_run", {31'b0, bus.load_ready}, 32'd0);
        fetch(32'h3FC);
        check("t1_instr", bus.fetch_instr, NOP);
        check("t1_valid", {31'b0, bus.fetch_valid}, 32'd1);
        check("t1_fault", {31'b0, bus.fetch_fault}, 32'd0);
        tick();
        check("t1_idle_valid", {31'b0, bus.fetch_valid}, 32'd0);

        // program load and back-to-back table fetch
        pulse_stop();
        check("stop_valid", {31'b0, bus.fetch_valid}, 32'd0);
        check("stop_state", {30'b0, bus.state_o}, 32'd1);
        load(32'h0, 32'h2D90_0093, 1'b0);
        load(32'h4, 32'h3E80_0113, 1'b0);
        load(32'h8, 32'h0010_0193, 1'b0);
        check("load_err_clear", {31'b0, bus.load_err}, 32'd0);
        check("load_valid_low", {31'b0, bus.fetch_valid}, 32'd0);
        check("load_instr_nop", bus.fetch_instr, NOP);
        pulse_start();
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_addr = vecs[i].addr;
            tick();
            check($sformatf("vec%0d_instr", i), bus.fetch_instr, vecs[i].instr);
            check($sformatf("vec%0d_valid", i), {31'b0, bus.fetch_valid}, 32'd1);
            check($sformatf("vec%0d_fault", i), {31'b0, bus.fetch_fault}, {31'b0, vecs[i].fault});
        end
        bus.fetch_req = 1'b0;

        // out-of-range and misaligned loads are dropped
        pulse_stop();
        load(32'h400, 32'h0000_0033, 1'b1);
        tick();
        check("t4_err_pulse_end", {31'b0, bus.load_err}, 32'd0);
        load(32'h2, 32'h0000_0033, 1'b1);
        pulse_start();
        fetch(32'h0);
        check("t4_word0", bus.fetch_instr, 32'h2D90_0093);

        // stall holds outputs and blocks the pending request
        bus.stall = 1'b1;
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_instr", i), bus.fetch_instr, 32'h2D90_0093);
            check($sformatf("stall%0d_valid", i), {31'b0, bus.fetch_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        tick();
        bus.fetch_req = 1'b0;
        check("stall_release", bus.fetch_instr, 32'h3E80_0113);

        // random traffic against a memory-image model
        pulse_stop();
        foreach (mem[i]) mem[i] = NOP;
        mem[0] = 32'h2D90_0093;
        mem[1] = 32'h3E80_0113;
        mem[2] = 32'h0010_0193;
        mst = 1;
        exp_instr = NOP;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            lv = 1'($urandom_range(0, 1));
            la = rand_addr();
            ld = $urandom;
            fr = $urandom_range(0, 3) != 0;
            fa = rand_addr();
            st = $urandom_range(0, 3) == 0;
            rs = $urandom_range(0, 15) == 0;
            rp = $urandom_range(0, 31) == 0;
            bus.load_valid = lv; bus.load_addr = la; bus.load_data = ld;
            bus.fetch_req = fr; bus.fetch_addr = fa; bus.stall = st;
            bus.run_start = rs; bus.run_stop = rp;
            exp_err = 1'b0;
            if (mst == 1) begin
                if (lv) begin
                    exp_err = !addr_ok(la);
                    if (addr_ok(la)) mem[la[9:2]] = ld;
                end
                if (rs) mst = 2;
            end else if (rp) begin
                mst = 1;
                exp_valid = 1'b0;
                exp_fault = 1'b0;
                exp_instr = NOP;
            end else if (!st) begin
                exp_valid = fr;
                exp_fault = fr && !addr_ok(fa);
                if (fr) exp_instr = addr_ok(fa) ? mem[fa[9:2]] : NOP;
            end
            tick();
            check("rnd_state", {30'b0, bus.state_o}, mst);
            check("rnd_ready", {31'b0, bus.load_ready}, {31'b0, mst == 1});
            check("rnd_load_err", {31'b0, bus.load_err}, {31'b0, exp_err});
            check("rnd_valid", {31'b0, bus.fetch_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("rnd_instr", bus.fetch_instr, exp_instr);
                check("rnd_fault", {31'b0, bus.fetch_fault}, {31'b0, exp_fault});
            end
            if (mst == 1) check("rnd_load_nop", bus.fetch_instr, NOP);
        end
        bus.load_valid = 1'b0; bus.fetch_req = 1'b0; bus.stall = 1'b0;
        bus.run_start = 1'b0; bus.run_stop = 1'b0;

        // async reset mid-RUN and mid-CLEAR
        if (mst == 1) pulse_start();
        fetch(32'h0);
        check("t6_pre_valid", {31'b0, bus.fetch_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_run_valid", {31'b0, bus.fetch_valid}, 32'd0);
        check("t6_run_instr", bus.fetch_instr, NOP);
        check("t6_run_state", {30'b0, bus.state_o}, 32'd0);
        check("t6_run_busy", {31'b0, bus.busy}, 32'd1);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("t6_mid_clear_busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_clear_state", {30'b0, bus.state_o}, 32'd0);
        check("t6_clear_ready", {31'b0, bus.load_ready}, 32'd0);
        tick();
        reset = 1'b0;
        wait_clear("t6");
        pulse_start();
        fetch(32'h0);
        check("t6_word0_cleared", bus.fetch_instr, NOP);
        fetch(32'h4);
        check("t6_word1_cleared", bus.fetch_instr, NOP);
        check("t6_word1_fault", {31'b0, bus.fetch_fault}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
